// File: rtl/regfile_pkg.sv
// Shared types and the read-resolution rule used by every read port and by dump capture.
package regfile_pkg;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} dump_state_e;

  // Ceiling widths; callers widen their operands and narrow the result.
  localparam int MAX_DATA_W = 64;
  localparam int MAX_ADDR_W = 16;

  typedef logic [MAX_DATA_W-1:0] word_t;
  typedef logic [MAX_ADDR_W-1:0] addr_t;

  // Hardwired zero first, then same-cycle write bypass, then stored value.
  function automatic word_t read_value(input logic  zero_reg,
                                       input addr_t addr,
                                       input logic  wr_eff,
                                       input addr_t wr_addr,
                                       input word_t wr_data,
                                       input word_t mem_val);
    word_t v;
    if (zero_reg && addr == '0)
      v = '0;
    else if (wr_eff && addr == wr_addr)
      v = wr_data;
    else
      v = mem_val;
    return v;
  endfunction

endpackage

// File: rtl/regfile_dump_fsm.sv
// Dump engine: walks addresses 0..DEPTH-1 over a valid/ready stream, capturing each word once.
module regfile_dump_fsm
  import regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dump_start,
  input  logic              dump_ready,
  input  logic [DATA_W-1:0] cap_data,
  output logic [ADDR_W-1:0] cap_addr,
  output logic              busy,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_last
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, nxt_addr;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;

  assign nxt_addr = addr_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  // cap_addr names the word that would be captured at the coming edge.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    last_d   = last_q;
    cap_addr = (state_q == SEND) ? nxt_addr : '0;
    case (state_q)
      IDLE: if (dump_start) begin
        state_d = SEND;
        addr_d  = '0;
        data_d  = cap_data;
        last_d  = (LAST_ADDR == '0);
      end
      SEND: if (dump_ready) begin
        if (addr_q == LAST_ADDR) begin
          state_d = IDLE;
          addr_d  = '0;
          last_d  = 1'b0;
        end else begin
          addr_d  = nxt_addr;
          data_d  = cap_data;
          last_d  = (nxt_addr == LAST_ADDR);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q == SEND);
  assign dump_valid = (state_q == SEND);
  assign dump_addr  = addr_q;
  assign dump_data  = data_q;
  assign dump_last  = last_q;

endmodule

// File: rtl/regfile_np.sv
// Parametrised register file: NUM_RD combinational read ports with write bypass,
// one write port, optional hardwired r0, and a streaming dump engine.
module regfile_np
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     dump_start,
  output logic                     busy,
  output logic                     dump_valid,
  input  logic                     dump_ready,
  output logic [ADDR_W-1:0]        dump_addr,
  output logic [DATA_W-1:0]        dump_data,
  output logic                     dump_last
);

  localparam int   DEPTH = 2**ADDR_W;
  localparam logic ZR    = (ZERO_REG != 0);

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic                         wr_eff;
  logic [ADDR_W-1:0]            cap_addr;
  logic [DATA_W-1:0]            cap_data;

  assign wr_eff = we && !(ZR && wr_addr == '0);

  always_ff @(posedge clk) begin
    if (rst)
      mem <= '0;
    else if (wr_eff)
      mem[wr_addr] <= wr_data;
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    assign a = rd_addr[k*ADDR_W +: ADDR_W];
    assign rd_data[k*DATA_W +: DATA_W] =
      DATA_W'(read_value(ZR, addr_t'(a), wr_eff, addr_t'(wr_addr),
                         word_t'(wr_data), word_t'(mem[a])));
  end

  // Dump capture resolves exactly like a read port, bypass included.
  assign cap_data =
    DATA_W'(read_value(ZR, addr_t'(cap_addr), wr_eff, addr_t'(wr_addr),
                       word_t'(wr_data), word_t'(mem[cap_addr])));

  regfile_dump_fsm #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_dump (
    .clk        (clk),
    .rst        (rst),
    .dump_start (dump_start),
    .dump_ready (dump_ready),
    .cap_data   (cap_data),
    .cap_addr   (cap_addr),
    .busy       (busy),
    .dump_valid (dump_valid),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data),
    .dump_last  (dump_last)
  );

endmodule

// File: tb/tb_regfile_np.sv
// Self-checking bench: one DUT with hardwired r0 and one without, sharing stimulus.
module tb_regfile_np;
  localparam int DW = 32, AW = 5, NR = 2, DEPTH = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, we, dump_start, dump_ready;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rdz, rdn;
  logic bz, bn, vz, vn, lz, ln;
  logic [AW-1:0] az, an;
  logic [DW-1:0] dz, dn;

  regfile_np #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut_z (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rdz), .we(we),
    .wr_addr(wr_addr), .wr_data(wr_data), .dump_start(dump_start), .busy(bz),
    .dump_valid(vz), .dump_ready(dump_ready), .dump_addr(az), .dump_data(dz),
    .dump_last(lz));

  regfile_np #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(0)) dut_n (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rdn), .we(we),
    .wr_addr(wr_addr), .wr_data(wr_data), .dump_start(dump_start), .busy(bn),
    .dump_valid(vn), .dump_ready(dump_ready), .dump_addr(an), .dump_data(dn),
    .dump_last(ln));

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Reference model: plain arrays, m1 with hardwired r0, m0 without.
  logic [31:0] m1 [DEPTH];
  logic [31:0] m0 [DEPTH];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        m1[i] <= '0;
        m0[i] <= '0;
      end
    end else if (we) begin
      if (wr_addr != 0) m1[wr_addr] <= wr_data;
      m0[wr_addr] <= wr_data;
    end
  end

  function automatic logic [31:0] mread(input bit z, input logic [4:0] a);
    if (z && a == 0) return 32'h0;
    if (we && !(z && wr_addr == 0) && wr_addr == a) return wr_data;
    return z ? m1[a] : m0[a];
  endfunction

  // Stream monitor: records accepted words and checks hold/last invariants.
  typedef struct {
    logic [4:0]  a;
    logic [31:0] dz, dn;
    logic        lz, ln;
  } word_rec_t;
  word_rec_t q[$];
  bit mon_en = 0;
  logic pv = 0, pr = 0, prst = 0, pl = 0;
  logic [4:0]  pa = '0;
  logic [31:0] pd = '0;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("last_flag", 32'(lz), 32'(vz && az == 5'd31));
      chk("busy_eq_valid", 32'(bz), 32'(vz));
      chk("pair_valid", 32'(vn), 32'(vz));
      chk("pair_addr", 32'(an), 32'(az));
      if (pv && !pr && !prst) begin
        chk("hold_valid", 32'(vz), 32'd1);
        chk("hold_addr", 32'(az), 32'(pa));
        chk("hold_data", dz, pd);
        chk("hold_last", 32'(lz), 32'(pl));
      end
      if (vz && dump_ready && !rst) q.push_back('{az, dz, dn, lz, ln});
    end
    pv <= vz; pr <= dump_ready; prst <= rst; pa <= az; pd <= dz; pl <= lz;
  end

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  r0, r1;
    logic [31:0] z0, z1, n0, n1;
  } vec_t;
  vec_t tv[7];

  initial begin
    #300000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int cnt;
    bit w3, found;
    rst = 1; we = 0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    dump_start = 0; dump_ready = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // Reset state
    @(negedge clk);
    chk("rst_busy", 32'(bz), 0); chk("rst_valid", 32'(vz), 0);
    chk("rst_addr", 32'(az), 0); chk("rst_data", dz, 0); chk("rst_last", 32'(lz), 0);
    chk("rst_data_n", dn, 0);
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = {5'(31 - a), 5'(a)};
      @(negedge clk);
      chk("rst_rd0", rdz[31:0], 0); chk("rst_rd1", rdz[63:32], 0);
      chk("rst_rd0_n", rdn[31:0], 0);
    end

    // Directed vectors
    tv[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0};
    tv[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    tv[2] = '{1'b1, 5'd0,  32'h1234,     5'd0,  5'd5,  32'h0, 32'hDEADBEEF, 32'h1234, 32'hDEADBEEF};
    tv[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0, 32'h0, 32'h1234, 32'h1234};
    tv[4] = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd30, 32'hCAFEF00D, 32'h0, 32'hCAFEF00D, 32'h0};
    tv[5] = '{1'b1, 5'd31, 32'h11111111, 5'd31, 5'd31, 32'h11111111, 32'h11111111, 32'h11111111, 32'h11111111};
    tv[6] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd5,  32'h11111111, 32'hDEADBEEF, 32'h11111111, 32'hDEADBEEF};
    @(posedge clk); #1;
    for (int i = 0; i < 7; i++) begin
      we = tv[i].we; wr_addr = tv[i].wa; wr_data = tv[i].wd;
      rd_addr = {tv[i].r1, tv[i].r0};
      @(negedge clk);
      chk($sformatf("vec%0d_z0", i), rdz[31:0], tv[i].z0);
      chk($sformatf("vec%0d_z1", i), rdz[63:32], tv[i].z1);
      chk($sformatf("vec%0d_n0", i), rdn[31:0], tv[i].n0);
      chk($sformatf("vec%0d_n1", i), rdn[63:32], tv[i].n1);
      @(posedge clk); #1;
    end

    // Random reads/writes against the model
    for (int i = 0; i < 300; i++) begin
      we = 1'($urandom_range(0, 1));
      wr_addr = 5'($urandom_range(0, 31));
      wr_data = $urandom;
      rd_addr = 10'($urandom);
      if ($urandom_range(0, 3) == 0) rd_addr[4:0] = wr_addr;
      if ($urandom_range(0, 3) == 0) rd_addr[9:5] = wr_addr;
      @(negedge clk);
      chk("rand_z0", rdz[31:0],  mread(1, rd_addr[4:0]));
      chk("rand_z1", rdz[63:32], mread(1, rd_addr[9:5]));
      chk("rand_n0", rdn[31:0],  mread(0, rd_addr[4:0]));
      chk("rand_n1", rdn[63:32], mread(0, rd_addr[9:5]));
      @(posedge clk); #1;
    end
    we = 0;

    // Full dump, ready held high
    rst = 1; @(posedge clk); #1 rst = 0;
    for (int i = 0; i < DEPTH; i++) begin
      we = 1; wr_addr = 5'(i); wr_data = 32'h100 + 32'(i);
      @(posedge clk); #1;
    end
    we = 0;
    q.delete(); mon_en = 1; dump_ready = 1; dump_start = 1;
    @(posedge clk); #1 dump_start = 0;
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (c == 0) begin chk("A_first_valid", 32'(vz), 1); chk("A_first_addr", 32'(az), 0); end
      if (!bz) break;
      cnt++;
      @(posedge clk); #1;
    end
    chk("A_busy_cycles", cnt, 32);
    chk("A_words", q.size(), 32);
    for (int i = 0; i < q.size() && i < DEPTH; i++) begin
      chk("A_addr", 32'(q[i].a), 32'(i));
      chk("A_data_z", q[i].dz, (i == 0) ? 32'h0 : 32'h100 + 32'(i));
      chk("A_data_n", q[i].dn, 32'h100 + 32'(i));
      chk("A_last_n", 32'(q[i].ln), 32'(i == 31));
    end
    @(posedge clk); #1;

    // Dump with ready toggling, mid-stream writes, ignored dump_start
    q.delete(); dump_ready = 0; dump_start = 1;
    @(posedge clk); #1 dump_start = 0;
    w3 = 0;
    for (int c = 0; c < 200; c++) begin
      dump_ready = c[0]; we = 0; dump_start = (c == 5);
      if (c == 2) begin we = 1; wr_addr = 5'd10; wr_data = 32'hBBBB; end
      if (!w3 && vz && az == 5'd3 && !dump_ready) begin
        we = 1; wr_addr = 5'd3; wr_data = 32'hAAAA; w3 = 1;
      end
      @(negedge clk);
      if (!bz) break;
      @(posedge clk); #1;
    end
    we = 0; dump_start = 0; dump_ready = 0;
    chk("B_r3_written", 32'(w3), 1);
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("B_no_restart", 32'(bz), 0);
    chk("B_words", q.size(), 32);
    for (int i = 0; i < q.size() && i < DEPTH; i++) begin
      logic [31:0] e;
      e = (i == 10) ? 32'hBBBB : 32'h100 + 32'(i);
      chk("B_addr", 32'(q[i].a), 32'(i));
      chk("B_data_n", q[i].dn, e);
      chk("B_data_z", q[i].dz, (i == 0) ? 32'h0 : e);
    end
    rd_addr = {5'd10, 5'd3};
    @(negedge clk);
    chk("B_r3_now", rdz[31:0], 32'hAAAA);
    chk("B_r10_now", rdz[63:32], 32'hBBBB);

    // Reset while word 7 is presented
    @(posedge clk); #1;
    q.delete(); dump_ready = 1; dump_start = 1;
    @(posedge clk); #1 dump_start = 0;
    found = 0;
    for (int c = 0; c < 100; c++) begin
      if (vz && az == 5'd7) begin rst = 1; found = 1; break; end
      @(posedge clk); #1;
    end
    chk("C_saw_word7", 32'(found), 1);
    @(posedge clk); #1 rst = 0; dump_ready = 0;
    @(negedge clk);
    chk("C_valid", 32'(vz), 0); chk("C_busy", 32'(bz), 0);
    chk("C_addr", 32'(az), 0); chk("C_data", dz, 0); chk("C_last", 32'(lz), 0);
    chk("C_words", q.size(), 7);
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = {5'(a), 5'(a)};
      @(negedge clk);
      chk("C_reg_z", rdz[31:0], 0);
      chk("C_reg_n", rdn[63:32], 0);
    end
    chk("C_no_more", q.size(), 7);
    @(posedge clk); #1;
    dump_start = 1; dump_ready = 1;
    @(posedge clk); #1 dump_start = 0;
    @(negedge clk);
    chk("C_restart_valid", 32'(vz), 1); chk("C_restart_addr", 32'(az), 0);
    chk("C_restart_data", dn, 0);
    for (int c = 0; c < 100; c++) begin
      if (!bz) break;
      @(posedge clk); #1;
      @(negedge clk);
    end
    chk("C_end_busy", 32'(bz), 0);
    chk("C_total_words", q.size(), 39);
    for (int i = 7; i < q.size(); i++) begin
      chk("C_addr", 32'(q[i].a), 32'(i - 7));
      chk("C_data_n", q[i].dn, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
